sram_arbiter_2p: RTL and testbench
==================================

// Module: sram_arbiter_2p
// PURPOSE
//  Two-requester arbiter in front of the single-cycle SRAM controller (start_n/rw/ready handshake).
//  Shares the one SRAM port between the frame writer (port 0) and the display reader (port 1).
//  Each requester runs a req/ack handshake; the arbiter serialises transactions and returns read data.
//  Arbitration is round-robin, or fixed priority when selected by parameter.
// PARAMETERS
//  ADDR_W      16  address width, passed unchanged to ctl_addr
//  DATA_W      16  data width for write and read data
//  FIXED_PRIO  0   0: round-robin; 1: port 0 always wins a tie
//  TMO_CYC     15  max cycles in BUSY before watchdog abort (4-bit counter is sufficient)
// PORTS
//  clk          in   1       clock
//  reset_n      in   1       asynchronous, active-low reset
//  pN_req       in   1       port N (N=0,1) request; held high with rw/addr/wdata stable until pN_ack
//  pN_rw        in   1       1 = read, 0 = write
//  pN_addr      in   ADDR_W  word address
//  pN_wdata     in   DATA_W  write data
//  pN_ack       out  1       one-cycle completion pulse
//  pN_rdata     out  DATA_W  read data; valid while pN_ack=1 and pN_rw=1
//  ctl_start_n  out  1       to SRAM controller; active-low start
//  ctl_rw       out  1       to controller rw
//  ctl_addr     out  ADDR_W  to controller addr_in
//  ctl_wdata    out  DATA_W  to controller data_write
//  ctl_ready    in   1       controller idle/ready
//  ctl_rdata    in   DATA_W  controller data_read
//  grant        out  1       index of the port currently or most recently served
//  busy         out  1       high in any state other than IDLE
//  err_tmo      out  1       sticky watchdog-abort flag
// BEHAVIOUR
//  Reset values: state=IDLE; ctl_start_n=1; ctl_rw=1; ctl_addr=0; ctl_wdata=0; p0/p1_ack=0;
//   p0/p1_rdata=0; grant=1 (port 0 wins the first tie); err_tmo=0; watchdog=0.
//  All outputs are registered. Reset mid-transaction aborts the transaction: no ack is issued.
//  States:
//   IDLE:  If (p0_req|p1_req) & ctl_ready, pick the winner, set grant, and latch its rw/addr/wdata
//          into ctl_*. Drive ctl_start_n=0 and go to ISSUE. Otherwise stay in IDLE.
//   ISSUE: ctl_start_n=0 for exactly this one cycle; the controller samples it here.
//          Next state BUSY, with ctl_start_n=1.
//   BUSY:  Wait for ctl_ready=1. The first BUSY cycle sees ready=0 (controller in read/write state).
//          On ctl_ready=1, capture ctl_rdata into p[grant]_rdata if rw=1, then go to DONE.
//          The watchdog counts BUSY cycles. At TMO_CYC: set err_tmo, go to DONE; rdata is not updated.
//   DONE:  p[grant]_ack=1 for this one cycle; the other ack stays 0. Next state IDLE unconditionally.
//  Request sampling:
//   req is sampled only in IDLE. A requester updates req on the edge where ack=1.
//   A still-high req in the IDLE cycle that follows is therefore a new request.
//  Latency: req seen in IDLE at cycle 0 -> ISSUE c1 -> BUSY c2 (ready=0) -> BUSY c3 (ready=1)
//   -> ack in c4. Peak throughput is 1 transaction per 5 cycles.
//  Arbitration:
//   Single requester: it wins.
//   Both requesting, FIXED_PRIO=0: the winner is ~grant (strict alternation).
//   Both requesting, FIXED_PRIO=1: port 0 wins.
//  ctl_addr, ctl_wdata and ctl_rw hold their last values while in IDLE. pN_rdata holds until the next read by port N.
//  A request that is not granted is held pending with no side effects; the loser wins the next tie in round-robin mode.
// TESTING
//  1. p0 read addr 0x0012, model returns 0xBEEF: one ctl_start_n low pulse with ctl_addr=0x0012, ctl_rw=1;
//     p0_ack in cycle 4 with p0_rdata=0xBEEF.
//  2. p1 write addr 0x00FF data 0x1234: ctl_rw=0, ctl_wdata=0x1234; p1_ack after 4 cycles;
//     a subsequent p0 read of 0x00FF returns 0x1234.
//  3. p0 and p1 both hold req for 6 transactions each, FIXED_PRIO=0: grant sequence 0,1,0,1,...;
//     both complete with no starvation.
//  4. FIXED_PRIO=1, both requesting continuously: all p0 transactions are served first;
//     p1 is served only when p0_req=0.
//  5. reset_n asserted in BUSY: all outputs return to reset values immediately; no ack is issued;
//     after release, a new p1 request completes normally.
//  6. Controller model holds ctl_ready=0 forever: after TMO_CYC BUSY cycles err_tmo=1 and an ack is issued;
//     IDLE resumes; err_tmo stays 1 until reset.

Source files
------------

// File: rtl/sram_arbiter_2p.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sram_arbiter_2p
//   Shares one single-cycle SRAM controller port between two requesters:
//   port 0 (frame writer) and port 1 (display reader). Transactions are
//   serialised through a four-state FSM (IDLE -> ISSUE -> BUSY -> DONE) and
//   read data is returned to the port that issued the read.
//
// Handshakes:
//   Requester side: pN_req is held high with pN_rw/pN_addr/pN_wdata stable
//   until pN_ack is seen; pN_ack is a one-cycle pulse and the requester
//   updates pN_req on that same edge. req is only sampled in IDLE, so a req
//   still high in the IDLE cycle after an ack is a new request.
//   Controller side: ctl_start_n is low for exactly one cycle (ISSUE) with
//   ctl_rw/ctl_addr/ctl_wdata valid; completion is ctl_ready returning high,
//   at which point ctl_rdata is valid for reads.
//
// Parameters:
//   ADDR_W, DATA_W  address / data widths
//   FIXED_PRIO      0: round-robin on ties, 1: port 0 always wins a tie
//   TMO_CYC         BUSY cycles allowed before the watchdog aborts (1..16)
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   pN_req/rw/addr/wdata (in)      requester N command
//   pN_ack, pN_rdata (out)         completion pulse, read data
//   ctl_start_n/rw/addr/wdata(out) to SRAM controller
//   ctl_ready, ctl_rdata (in)      from SRAM controller
//   grant (out)                    port currently or most recently served
//   busy (out)                     high whenever the FSM is not in IDLE
//   err_tmo (out)                  sticky watchdog-abort flag
//   dbg_state (out)                FSM state, for observation only
// ---------------------------------------------------------------------------
module sram_arbiter_2p #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0,
    parameter int TMO_CYC    = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p0_req,
    input  logic              p0_rw,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_rw,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ctl_start_n,
    output logic              ctl_rw,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_wdata,
    input  logic              ctl_ready,
    input  logic [DATA_W-1:0] ctl_rdata,
    output logic              grant,
    output logic              busy,
    output logic              err_tmo,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Watchdog value seen during the last permitted BUSY cycle.
    localparam logic [3:0] WDOG_LAST = 4'(TMO_CYC - 1);

    logic [1:0] state;
    logic [3:0] wdog;
    logic       win;

    assign dbg_state = state;

    // Winner for the IDLE decision. On a tie, round-robin hands the port
    // to whichever side was not served last (grant resets to 1, so port 0
    // wins the very first tie).
    always_comb begin
        win = p1_req;
        if (p0_req && p1_req) begin
            win = (FIXED_PRIO != 0) ? 1'b0 : ~grant;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            wdog        <= '0;
            ctl_start_n <= 1'b1;
            ctl_rw      <= 1'b1;
            ctl_addr    <= '0;
            ctl_wdata   <= '0;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p0_rdata    <= '0;
            p1_rdata    <= '0;
            grant       <= 1'b1;
            busy        <= 1'b0;
            err_tmo     <= 1'b0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if ((p0_req || p1_req) && ctl_ready) begin
                        grant       <= win;
                        ctl_rw      <= win ? p1_rw    : p0_rw;
                        ctl_addr    <= win ? p1_addr  : p0_addr;
                        ctl_wdata   <= win ? p1_wdata : p0_wdata;
                        ctl_start_n <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ctl_start_n <= 1'b1;
                    wdog        <= '0;
                    state       <= S_BUSY;
                end
                S_BUSY: begin
                    if (ctl_ready) begin
                        if (ctl_rw) begin
                            if (grant) p1_rdata <= ctl_rdata;
                            else       p0_rdata <= ctl_rdata;
                        end
                        p0_ack <= ~grant;
                        p1_ack <= grant;
                        state  <= S_DONE;
                    end else if (wdog == WDOG_LAST) begin
                        // Abort: the requester still gets its ack so it can
                        // move on, but its rdata is left untouched.
                        err_tmo <= 1'b1;
                        p0_ack  <= ~grant;
                        p1_ack  <= grant;
                        state   <= S_DONE;
                    end else begin
                        wdog <= wdog + 4'd1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter_2p.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_sram_arbiter_2p
//   Two arbiter instances share one clock/reset: index 0 is round-robin,
//   index 1 is fixed priority. Each has its own single-cycle SRAM controller
//   model (ready drops for one cycle after a start pulse, or forever while
//   hang is set). A reference model holds the expected memory contents,
//   arbitration history and per-port read data.
// ---------------------------------------------------------------------------
module tb_sram_arbiter_2p;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int TMO = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals (index = instance) ----------------
    logic          p0_req [2];
    logic          p0_rw  [2];
    logic [AW-1:0] p0_addr [2];
    logic [DW-1:0] p0_wdata [2];
    logic          p0_ack [2];
    logic [DW-1:0] p0_rdata [2];
    logic          p1_req [2];
    logic          p1_rw  [2];
    logic [AW-1:0] p1_addr [2];
    logic [DW-1:0] p1_wdata [2];
    logic          p1_ack [2];
    logic [DW-1:0] p1_rdata [2];
    logic          ctl_start_n [2];
    logic          ctl_rw [2];
    logic [AW-1:0] ctl_addr [2];
    logic [DW-1:0] ctl_wdata [2];
    logic          grant [2];
    logic          busy [2];
    logic          err_tmo [2];
    logic [1:0]    dbg_state [2];
    logic          hang [2];

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h12) ? 16'hBEEF : {a ^ 8'h5A, a};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic          m_ready;
        logic [DW-1:0] m_rdata;
        logic [DW-1:0] mem [256];
        logic          pend;
        logic          l_rw;
        logic [7:0]    l_addr;
        logic [DW-1:0] l_wdata;

        sram_arbiter_2p #(
            .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(g), .TMO_CYC(TMO)
        ) u_dut (
            .clk(clk), .reset_n(reset_n),
            .p0_req(p0_req[g]), .p0_rw(p0_rw[g]), .p0_addr(p0_addr[g]),
            .p0_wdata(p0_wdata[g]), .p0_ack(p0_ack[g]), .p0_rdata(p0_rdata[g]),
            .p1_req(p1_req[g]), .p1_rw(p1_rw[g]), .p1_addr(p1_addr[g]),
            .p1_wdata(p1_wdata[g]), .p1_ack(p1_ack[g]), .p1_rdata(p1_rdata[g]),
            .ctl_start_n(ctl_start_n[g]), .ctl_rw(ctl_rw[g]),
            .ctl_addr(ctl_addr[g]), .ctl_wdata(ctl_wdata[g]),
            .ctl_ready(m_ready), .ctl_rdata(m_rdata),
            .grant(grant[g]), .busy(busy[g]), .err_tmo(err_tmo[g]),
            .dbg_state(dbg_state[g])
        );

        // Single-cycle SRAM controller model.
        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
                pend    <= 1'b0;
                m_ready <= 1'b1;
                m_rdata <= '0;
                l_rw    <= 1'b1;
                l_addr  <= '0;
                l_wdata <= '0;
            end else if (pend) begin
                if (!hang[g]) begin
                    pend    <= 1'b0;
                    m_ready <= 1'b1;
                    if (l_rw) m_rdata <= mem[l_addr];
                    else      mem[l_addr] <= l_wdata;
                end
            end else if (!ctl_start_n[g]) begin
                pend    <= 1'b1;
                m_ready <= 1'b0;
                l_rw    <= ctl_rw[g];
                l_addr  <= ctl_addr[g][7:0];
                l_wdata <= ctl_wdata[g];
            end
        end
    end

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    logic [15:0] ref_mem [2][256];
    logic [15:0] last_rd [4];     // expected pN_rdata, index d*2+p
    logic        last_win [2];

    task automatic ref_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) ref_mem[d][i] = init_val(8'(i));
            last_win[d] = 1'b1;
        end
        for (int k = 0; k < 4; k++) last_rd[k] = '0;
    endtask

    // ---------------- driver helpers ----------------
    task automatic drive(input int d, input int p, input logic req, input logic rw,
                         input logic [15:0] addr, input logic [15:0] wdata);
        if (p == 0) begin
            p0_req[d] = req; p0_rw[d] = rw; p0_addr[d] = addr; p0_wdata[d] = wdata;
        end else begin
            p1_req[d] = req; p1_rw[d] = rw; p1_addr[d] = addr; p1_wdata[d] = wdata;
        end
    endtask

    task automatic drive_idle(input int d, input int p);
        drive(d, p, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
    endtask

    function automatic logic get_ack(input int d, input int p);
        return (p == 0) ? p0_ack[d] : p1_ack[d];
    endfunction

    function automatic logic [15:0] get_rdata(input int d, input int p);
        return (p == 0) ? p0_rdata[d] : p1_rdata[d];
    endfunction

    task automatic check_reset_vals(input int d);
        check($sformatf("rst%0d_start_n", d), ctl_start_n[d], 1);
        check($sformatf("rst%0d_rw", d), ctl_rw[d], 1);
        check($sformatf("rst%0d_addr", d), ctl_addr[d], 0);
        check($sformatf("rst%0d_wdata", d), ctl_wdata[d], 0);
        check($sformatf("rst%0d_ack0", d), p0_ack[d], 0);
        check($sformatf("rst%0d_ack1", d), p1_ack[d], 0);
        check($sformatf("rst%0d_rdata0", d), p0_rdata[d], 0);
        check($sformatf("rst%0d_rdata1", d), p1_rdata[d], 0);
        check($sformatf("rst%0d_grant", d), grant[d], 1);
        check($sformatf("rst%0d_busy", d), busy[d], 0);
        check($sformatf("rst%0d_err_tmo", d), err_tmo[d], 0);
        check($sformatf("rst%0d_state", d), dbg_state[d], 0);
    endtask

    // One isolated transaction: checks latency 4, one start pulse carrying
    // the request, rdata at ack, the other port untouched, and hold in IDLE.
    task automatic one_txn(input string nm, input int d, input int p, input logic rw,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] exp_rd);
        int lat;
        int starts;
        int k;
        k = d * 2 + p;
        lat = 99;
        starts = 0;
        @(posedge clk); #1;
        drive(d, p, 1'b1, rw, addr, wdata);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!ctl_start_n[d]) begin
                starts++;
                check({nm, "_ctl_addr"}, ctl_addr[d], addr);
                check({nm, "_ctl_rw"}, ctl_rw[d], rw);
                if (!rw) check({nm, "_ctl_wdata"}, ctl_wdata[d], wdata);
            end
            if (get_ack(d, p)) begin
                lat = n;
                check({nm, "_rdata"}, get_rdata(d, p), exp_rd);
                check({nm, "_other_ack"}, get_ack(d, 1 - p), 0);
                check({nm, "_other_rdata"}, get_rdata(d, 1 - p), last_rd[d * 2 + 1 - p]);
                check({nm, "_grant"}, grant[d], p);
                break;
            end
        end
        check({nm, "_latency"}, lat, 4);
        check({nm, "_starts"}, starts, 1);
        @(posedge clk); #1;
        drive_idle(d, p);
        @(negedge clk);
        check({nm, "_hold_addr"}, ctl_addr[d], addr);
        check({nm, "_hold_rw"}, ctl_rw[d], rw);
        check({nm, "_idle_busy"}, busy[d], 0);
        last_win[d] = p[0];
        if (rw) last_rd[k] = exp_rd;
        else    ref_mem[d][addr[7:0]] = wdata;
    endtask

    // ---------------- transaction engine with reference model ----------------
    txn_t        tq [4][$];
    txn_t        cur [4];
    bit          act [4];
    bit          ackd [4];
    logic [15:0] exp_q [4][$];
    int          glog [2][$];
    int          cnt [2];       // cycles since start pulse, 0 = idle
    int          srv [2];
    logic        prev_idle [2];
    logic [1:0]  prev_req [2];
    bit          gaps;

    function automatic txn_t rand_txn(input int amax);
        txn_t t;
        t.rw    = 1'($urandom_range(0, 1));
        t.addr  = 16'($urandom_range(0, amax));
        t.wdata = 16'($urandom);
        return t;
    endfunction

    task automatic eng_drive();
        for (int k = 0; k < 4; k++) begin
            if (ackd[k]) begin
                act[k]  = 1'b0;
                ackd[k] = 1'b0;
            end
            if (!act[k] && tq[k].size() > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
                cur[k] = tq[k].pop_front();
                act[k] = 1'b1;
                drive(k / 2, k % 2, 1'b1, cur[k].rw, cur[k].addr, cur[k].wdata);
            end else if (!act[k]) begin
                drive_idle(k / 2, k % 2);
            end
        end
    endtask

    task automatic eng_mon();
        logic exp_start;
        logic w;
        logic ea;
        int   k;
        for (int d = 0; d < 2; d++) begin
            if (cnt[d] > 0) cnt[d] = (cnt[d] == 4) ? 0 : cnt[d] + 1;
            exp_start = prev_idle[d] && (prev_req[d] != 2'b00);
            check($sformatf("eng%0d_start_n", d), ctl_start_n[d], !exp_start);
            if (exp_start && !ctl_start_n[d]) begin
                if (prev_req[d] == 2'b11) w = (d == 1) ? 1'b0 : ~last_win[d];
                else                      w = prev_req[d][1];
                check($sformatf("eng%0d_grant", d), grant[d], w);
                k = d * 2 + int'(w);
                check($sformatf("eng%0d_ctl_addr", d), ctl_addr[d], cur[k].addr);
                check($sformatf("eng%0d_ctl_rw", d), ctl_rw[d], cur[k].rw);
                if (cur[k].rw) last_rd[k] = ref_mem[d][cur[k].addr[7:0]];
                else begin
                    check($sformatf("eng%0d_ctl_wdata", d), ctl_wdata[d], cur[k].wdata);
                    ref_mem[d][cur[k].addr[7:0]] = cur[k].wdata;
                end
                exp_q[k].push_back(last_rd[k]);
                glog[d].push_back(int'(grant[d]));
                last_win[d] = w;
                srv[d] = int'(w);
                cnt[d] = 1;
            end
            check($sformatf("eng%0d_busy", d), busy[d], cnt[d] != 0);
            for (int p = 0; p < 2; p++) begin
                ea = (cnt[d] == 4) && (srv[d] == p);
                check($sformatf("eng%0d_ack%0d", d, p), get_ack(d, p), ea);
                if (get_ack(d, p)) begin
                    ackd[d * 2 + p] = 1'b1;
                    if (ea) begin
                        if (exp_q[d * 2 + p].size() > 0)
                            check($sformatf("eng%0d_rdata%0d", d, p), get_rdata(d, p),
                                  exp_q[d * 2 + p].pop_front());
                        else
                            check($sformatf("eng%0d_exp_empty%0d", d, p), 1, 0);
                    end
                end
            end
            prev_idle[d] = (cnt[d] == 0);
            prev_req[d]  = {p1_req[d], p0_req[d]};
        end
    endtask

    task automatic run_engine(input string nm, input bit with_gaps, input int budget);
        bit done;
        gaps = with_gaps;
        done = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cnt[d] = 0; srv[d] = 0; prev_idle[d] = 1'b1; prev_req[d] = 2'b00;
        end
        for (int k = 0; k < 4; k++) begin act[k] = 1'b0; ackd[k] = 1'b0; end
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk); #1;
            eng_drive();
            @(negedge clk);
            eng_mon();
            done = (cnt[0] == 0) && (cnt[1] == 0);
            for (int k = 0; k < 4; k++) if (act[k] || tq[k].size() > 0) done = 1'b0;
        end
        check({nm, "_completed"}, done, 1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_exp_q%0d_empty", nm, k), exp_q[k].size(), 0);
            exp_q[k].delete();
            tq[k].delete();
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int          d;
        int          p;
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;   // expected pN_rdata at the ack
    } vec_t;

    vec_t vecs [9];

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int starts;
        bit early_err;
        logic [15:0] e;

        vecs[0] = '{0, 0, 1'b1, 16'h0012, 16'h0000, 16'hBEEF};
        vecs[1] = '{0, 1, 1'b0, 16'h00FF, 16'h1234, 16'h0000};
        vecs[2] = '{0, 0, 1'b1, 16'h00FF, 16'h0000, 16'h1234};
        vecs[3] = '{0, 1, 1'b1, 16'h00FF, 16'h0000, 16'h1234};
        vecs[4] = '{1, 1, 1'b0, 16'h0020, 16'hA5A5, 16'h0000};
        vecs[5] = '{1, 0, 1'b1, 16'h0020, 16'h0000, 16'hA5A5};
        vecs[6] = '{0, 0, 1'b0, 16'h0012, 16'h0001, 16'h1234};
        vecs[7] = '{0, 1, 1'b1, 16'h0012, 16'h0000, 16'h0001};
        vecs[8] = '{1, 1, 1'b1, 16'h0033, 16'h0000, 16'h6933};

        for (int d = 0; d < 2; d++) begin
            hang[d] = 1'b0;
            drive(d, 0, 1'b0, 1'b0, '0, '0);
            drive(d, 1, 1'b0, 1'b0, '0, '0);
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        reset_n = 1'b1;
        ref_reset();

        // Table: isolated single-requester transactions.
        for (int i = 0; i < 9; i++)
            one_txn($sformatf("vec%0d", i), vecs[i].d, vecs[i].p, vecs[i].rw,
                    vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

        // Round-robin with both ports requesting continuously.
        glog[0].delete();
        for (int i = 0; i < 6; i++) begin
            tq[0].push_back(rand_txn(15));
            tq[1].push_back(rand_txn(15));
        end
        run_engine("rr", 1'b0, 200);
        check("rr_grant_count", glog[0].size(), 12);
        for (int i = 0; i < glog[0].size(); i++)
            check($sformatf("rr_grant_seq%0d", i), glog[0][i], i % 2);

        // Fixed priority with both ports requesting continuously.
        glog[1].delete();
        for (int i = 0; i < 6; i++) begin
            tq[2].push_back(rand_txn(15));
            tq[3].push_back(rand_txn(15));
        end
        run_engine("fix", 1'b0, 200);
        check("fix_grant_count", glog[1].size(), 12);
        for (int i = 0; i < glog[1].size(); i++)
            check($sformatf("fix_grant_seq%0d", i), glog[1][i], (i < 6) ? 0 : 1);

        // Random traffic on all four ports of both instances.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 20; i++) tq[k].push_back(rand_txn(15));
        run_engine("rand", 1'b1, 3000);

        // Watchdog: controller never returns ready.
        hang[0] = 1'b1;
        lat = 99;
        starts = 0;
        early_err = 1'b0;
        @(posedge clk); #1;
        drive(0, 0, 1'b1, 1'b1, 16'h0005, 16'h0000);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!ctl_start_n[0]) starts++;
            if (p0_ack[0]) begin
                lat = n;
                check("tmo_err_at_ack", err_tmo[0], 1);
                check("tmo_rdata_kept", p0_rdata[0], last_rd[0]);
                break;
            end
            if (err_tmo[0]) early_err = 1'b1;
        end
        check("tmo_latency", lat, TMO + 2);
        check("tmo_starts", starts, 1);
        check("tmo_no_early_err", early_err, 0);
        @(posedge clk); #1;
        drive_idle(0, 0);
        hang[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("tmo_idle_busy", busy[0], 0);
        check("tmo_sticky", err_tmo[0], 1);
        last_win[0] = 1'b0;
        e = ref_mem[0][8'h40];
        one_txn("post_tmo", 0, 1, 1'b1, 16'h0040, 16'h0000, e);
        check("tmo_sticky_after", err_tmo[0], 1);

        // Reset asserted while BUSY.
        @(posedge clk); #1;
        drive(0, 1, 1'b1, 1'b1, 16'h0041, 16'h0000);
        repeat (3) @(negedge clk);
        check("rstb_in_busy", busy[0], 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals(0);
        drive_idle(0, 1);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("rstb_no_ack0", p0_ack[0], 0);
            check("rstb_no_ack1", p1_ack[0], 0);
        end
        reset_n = 1'b1;
        ref_reset();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("rstb_post_no_ack", p1_ack[0], 0);
        end
        e = ref_mem[0][8'h41];
        one_txn("post_rst", 0, 1, 1'b1, 16'h0041, 16'h0000, e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
